fibo_job_sequencer: RTL

Front-end request sequencer for the Fibonacci calculator. Buffers incoming job requests in a small FIFO and launches them one at a time on the calculator's start/index inputs. Waits for the calculator's done pulse, captures the 16-bit result and presents it downstream on a valid/ready result port. Enforces a per-job timeout and flags protocol violations from the calculator side.

---
 rtl/fibo_job_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fibo_job_sequencer.sv
// -----------------------------------------------------------------------------
// fibo_job_sequencer
//
// Front-end job sequencer for the Fibonacci calculator. Incoming requests are
// buffered in a small FIFO and launched one at a time on the calculator's
// start/index inputs. The sequencer waits for the calculator's done pulse (or a
// per-job timeout), captures the result into a single result slot and presents
// it downstream on a valid/ready port. A done pulse that arrives while no job
// is outstanding sets a sticky protocol-error flag.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_n is the requested index
//   calc_start, calc_n    one-cycle launch pulse and held index to calculator
//   calc_done/calc_result calculator completion pulse and its 16-bit result
//   res_valid/res_ready   result handshake; res_n, res_value, res_timeout
//   busy                  a job is in flight or requests are queued
//   err_spurious          sticky: calc_done seen while no job was waiting
// -----------------------------------------------------------------------------
module fibo_job_sequencer #(
  parameter int DEPTH   = 4,   // request FIFO entries, power of two, >= 2
  parameter int TIMEOUT = 63   // WAIT cycles before a job is retired, 1..255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_n,
  output logic        calc_start,
  output logic [4:0]  calc_n,
  input  logic        calc_done,
  input  logic [15:0] calc_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_n,
  output logic [15:0] res_value,
  output logic        res_timeout,
  output logic        busy,
  output logic        err_spurious
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [4:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [7:0]       wait_cnt;

  logic push, pop, slot_free, retire_done, retire_tmo;

  assign req_ready   = (count != FULL_CNT);
  assign push        = req_valid && req_ready;
  assign pop         = (state == S_LAUNCH);
  // The slot counts as free when it is empty or is being drained this cycle,
  // so a retiring job can never overwrite an unconsumed result.
  assign slot_free   = !res_valid || res_ready;
  assign retire_done = (state == S_WAIT) && calc_done;
  // A done pulse in the timeout cycle wins over the timeout.
  assign retire_tmo  = (state == S_WAIT) && !calc_done && (wait_cnt == TIMEOUT_CNT);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if ((count != '0) && slot_free) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (retire_done || retire_tmo) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: the entry storage has no reset; count and pointers decide which
  // entries are meaningful, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_n;
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      calc_start   <= 1'b0;
      calc_n       <= '0;
      res_valid    <= 1'b0;
      res_n        <= '0;
      res_value    <= '0;
      res_timeout  <= 1'b0;
      busy         <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      busy  <= (state_nxt != S_IDLE) || (count_nxt != '0);

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      // Launch outputs are registered: raise start and load the FIFO head on
      // the edge that enters LAUNCH; calc_n then holds until the next launch.
      calc_start <= (state_nxt == S_LAUNCH);
      if (state_nxt == S_LAUNCH) calc_n <= mem[rd_ptr];

      // Cleared during LAUNCH so the first WAIT cycle sees zero; saturates.
      if (state == S_LAUNCH)
        wait_cnt <= '0;
      else if ((state == S_WAIT) && (wait_cnt != 8'hFF))
        wait_cnt <= wait_cnt + 8'd1;

      if (retire_done) begin
        res_value   <= calc_result;
        res_n       <= calc_n;
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
      end else if (retire_tmo) begin
        res_value   <= '0;
        res_n       <= calc_n;
        res_timeout <= 1'b1;
        res_valid   <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      if (calc_done && (state != S_WAIT)) err_spurious <= 1'b1;
    end
  end

endmodule
